// File: rtl/rst_seq_pkg.sv
// Reset sequencer shared types: FSM state encodings and
// the down-counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable saturating down-counter with zero flag.
// Ports: clk, rst (sync), load, load_val -> cnt, zero.
module rst_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset release for NUM_DOMAINS domains with sw reset.
// Ports: CLK, RST, SW_RST_REQ -> SW_RST_ACK, DOM_RST, RST_DONE.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  output logic                   SW_RST_ACK,
  output logic [NUM_DOMAINS-1:0] DOM_RST,
  output logic                   RST_DONE
);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_nd
    $error("rst_seq_ctrl: NUM_DOMAINS must be 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_seq_ctrl: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("rst_seq_ctrl: STAGE_GAP must be >= 1");
  end

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Counter holds N-1 so the zero flag lines up with edge N.
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_DOMAINS - 1);

  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [NUM_DOMAINS-1:0] dom, dom_n;
  logic done, done_n;
  logic ack, ack_n;
  logic ld;
  logic [CW-1:0] ld_val;
  logic [CW-1:0] cnt;
  logic zero;

  rst_seq_cnt #(.W(CW)) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (ld),
    .load_val (ld_val),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dom_n   = dom;
    done_n  = done;
    ack_n   = 1'b0;
    ld      = 1'b0;
    ld_val  = HOLD_LD;
    unique case (state)
      ST_ASSERT: begin
        dom_n   = '1;
        done_n  = 1'b0;
        idx_n   = '0;
        ld      = 1'b1;
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (zero) begin
          dom_n[0] = 1'b0;
          if (NUM_DOMAINS == 1) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RELEASE;
            idx_n   = IW'(1);
            ld      = 1'b1;
            ld_val  = GAP_LD;
          end
        end
      end
      ST_RELEASE: begin
        if (zero) begin
          dom_n = dom & ~(NUM_DOMAINS'(1) << idx);
          if (idx == LAST) begin
            state_n = ST_DONE;
          end else begin
            idx_n  = idx + 1'b1;
            ld     = 1'b1;
            ld_val = GAP_LD;
          end
        end
      end
      ST_DONE: begin
        // A request already held on arrival counts as new.
        if (SW_RST_REQ) begin
          dom_n   = '1;
          done_n  = 1'b0;
          ack_n   = 1'b1;
          idx_n   = '0;
          ld      = 1'b1;
          state_n = ST_HOLD;
        end else begin
          done_n = 1'b1;
        end
      end
      default: state_n = ST_ASSERT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_ASSERT;
      idx   <= '0;
      dom   <= '1;
      done  <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dom   <= dom_n;
      done  <= done_n;
      ack   <= ack_n;
    end
  end

  assign DOM_RST    = dom;
  assign RST_DONE   = done;
  assign SW_RST_ACK = ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl (default and
// degenerate 1-domain/1-hold configurations).
module tb_rst_seq_ctrl;

  typedef struct {
    int         at;
    logic [3:0] dom;
    logic       done;
    logic       ack;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst, req, rst2, req2;
  logic ack, done, ack2, done2;
  logic [3:0] dom;
  logic [0:0] dom2;

  int en = 0;
  int nchk = 0;
  int nfail = 0;
  int acks = 0;
  exp_t q[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) en <= en + 1;

  rst_seq_ctrl #(
    .NUM_DOMAINS (4),
    .HOLD_CYCLES (16),
    .STAGE_GAP   (8)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .SW_RST_REQ (req),
    .SW_RST_ACK (ack),
    .DOM_RST    (dom),
    .RST_DONE   (done)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (8)
  ) dut2 (
    .CLK        (clk),
    .RST        (rst2),
    .SW_RST_REQ (req2),
    .SW_RST_ACK (ack2),
    .DOM_RST    (dom2),
    .RST_DONE   (done2)
  );

  task automatic push(input int w, input int at,
                      input logic [3:0] d, input logic dn,
                      input logic a, input string nm);
    exp_t e;
    e.at = at; e.dom = d; e.done = dn; e.ack = a; e.nm = nm;
    if (w == 0) q.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic chk(input exp_t e, input logic [3:0] d,
                     input logic dn, input logic a);
    nchk++;
    if (e.at != en || d !== e.dom || dn !== e.done ||
        a !== e.ack) begin
      nfail++;
      $display("FAIL %s @%0d: got edge=%0d dom=%h done=%b ack=%b, want edge=%0d dom=%h done=%b ack=%b",
               e.nm, e.at, en, d, dn, a, e.at, e.dom, e.done, e.ack);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) acks++;
    while (q.size() > 0 && q[0].at <= en) begin
      e = q.pop_front();
      chk(e, dom, done, ack);
    end
    while (q2.size() > 0 && q2[0].at <= en) begin
      e = q2.pop_front();
      chk(e, {3'b000, dom2}, done2, ack2);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_to(input int e);
    while (en < e) @(negedge clk);
  endtask

  // Release schedule of the 4-domain DUT for a start edge k.
  task automatic push_seq(input int k, input bit fin_ack);
    push(0, k + 15, 4'hF, 1'b0, 1'b0, "hold_end");
    push(0, k + 16, 4'hE, 1'b0, 1'b0, "rel0");
    push(0, k + 23, 4'hE, 1'b0, 1'b0, "pre_rel1");
    push(0, k + 24, 4'hC, 1'b0, 1'b0, "rel1");
    push(0, k + 31, 4'hC, 1'b0, 1'b0, "pre_rel2");
    push(0, k + 32, 4'h8, 1'b0, 1'b0, "rel2");
    push(0, k + 39, 4'h8, 1'b0, 1'b0, "pre_rel3");
    push(0, k + 40, 4'h0, 1'b0, 1'b0, "rel3");
    if (fin_ack)
      push(0, k + 41, 4'hF, 1'b0, 1'b1, "held_req_ack");
    else
      push(0, k + 41, 4'h0, 1'b1, 1'b0, "done");
  endtask

  initial begin
    int k, m, j, c;
    rst = 1'b1; req = 1'b0; rst2 = 1'b1; req2 = 1'b0;
    push(0, 1, 4'hF, 1'b0, 1'b0, "por1");
    push(0, 3, 4'hF, 1'b0, 1'b0, "por3");
    push(1, 3, 4'h1, 1'b0, 1'b0, "por_deg");

    // Power-on release of both DUTs.
    wait_to(5);
    rst = 1'b0; rst2 = 1'b0;
    k = en + 1;
    push_seq(k, 1'b0);
    push(1, k,     4'h1, 1'b0, 1'b0, "deg_hold");
    push(1, k + 1, 4'h0, 1'b0, 1'b0, "deg_rel");
    push(1, k + 2, 4'h0, 1'b1, 1'b0, "deg_done");
    push(1, k + 3, 4'h0, 1'b1, 1'b0, "deg_stay");
    wait_to(k + 44);

    // Software reset from DONE.
    req = 1'b1;
    m = en + 1;
    push(0, m,     4'hF, 1'b0, 1'b1, "sw_ack");
    push(0, m + 1, 4'hF, 1'b0, 1'b0, "sw_ack_end");
    push_seq(m, 1'b0);
    tick();
    req = 1'b0;
    wait_to(m + 44);

    // Early request held through the sequence.
    rst = 1'b1;
    push(0, en + 1, 4'hF, 1'b0, 1'b0, "rst_again");
    tick(); tick();
    rst = 1'b0;
    k = en + 1;
    push_seq(k, 1'b1);
    wait_to(k + 19);
    req = 1'b1;
    wait_to(k + 41);
    req = 1'b0;
    m = k + 41;
    push(0, m + 1, 4'hF, 1'b0, 1'b0, "held_ack_end");
    push_seq(m, 1'b0);
    wait_to(m + 44);

    // Mid-sequence reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    k = en + 1;
    push(0, k + 16, 4'hE, 1'b0, 1'b0, "mid_rel0");
    push(0, k + 24, 4'hC, 1'b0, 1'b0, "mid_rel1");
    push(0, k + 27, 4'hC, 1'b0, 1'b0, "mid_pre");
    wait_to(k + 27);
    rst = 1'b1;
    push(0, k + 28, 4'hF, 1'b0, 1'b0, "mid_rst");
    tick();
    rst = 1'b0;
    j = en + 1;
    push_seq(j, 1'b0);
    wait_to(j + 44);

    // Reset and request colliding in DONE.
    req = 1'b1; rst = 1'b1;
    c = en + 1;
    push(0, c,     4'hF, 1'b0, 1'b0, "collide");
    push(0, c + 1, 4'hF, 1'b0, 1'b0, "collide_hold");
    tick(); tick();
    req = 1'b0; rst = 1'b0;
    k = en + 1;
    push_seq(k, 1'b0);
    wait_to(k + 44);

    tick();
    nchk++;
    if (acks != 2) begin
      nfail++;
      $display("FAIL ack_count: got %0d, want 2", acks);
    end
    nchk++;
    if (q.size() != 0 || q2.size() != 0) begin
      nfail++;
      $display("FAIL leftover: got %0d/%0d pending, want 0/0",
               q.size(), q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 4: number of downstream reset domains, legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all domains stay asserted after reset release, legal range >= 1.
REQ-003 Parameter STAGE_GAP, default 8: cycles between consecutive domain releases, legal range >= 1.
REQ-004 CLK  input  1  block clock; the only clock.
REQ-005 RST  input  1  reset, synchronous, active-high; comes from the reset synchronizer's SYNC_RST output.
REQ-006 SW_RST_REQ  input  1  software reset request, level; requester holds it high until it sees SW_RST_ACK.
REQ-007 SW_RST_ACK  output  1  one-cycle acknowledge pulse for an accepted software reset.
REQ-008 DOM_RST  output  NUM_DOMAINS  per-domain reset, active-high; bit i releases before bit i+1.
REQ-009 RST_DONE  output  1  high when every domain is released.

Function
REQ-010 The block SHALL register every output; no output is combinational from an input.
REQ-011 The FSM SHALL have the states ASSERT, HOLD, RELEASE, DONE.
REQ-012 ASSERT behaviour: DOM_RST is all ones, RST_DONE=0, SW_RST_ACK=0; the FSM stays in ASSERT while RST=1.
REQ-013 Edge k is the first rising edge with RST sampled 0. At edge k the FSM SHALL go ASSERT->HOLD and load the counter.
REQ-014 DOM_RST[0] SHALL go low at edge k+HOLD_CYCLES; at that edge the FSM enters RELEASE.
REQ-015 DOM_RST[i] SHALL go low at edge k+HOLD_CYCLES+i*STAGE_GAP. Released bits SHALL stay low.
REQ-016 After the last domain is released, the FSM SHALL enter DONE and RST_DONE SHALL rise at edge k+HOLD_CYCLES+(NUM_DOMAINS-1)*STAGE_GAP+1.
REQ-017 Software reset in DONE: SW_RST_REQ=1 sampled at edge m SHALL cause all of the following at edge m:
  - DOM_RST set to all ones;
  - RST_DONE cleared;
  - SW_RST_ACK set high for exactly one cycle;
  - FSM to HOLD.
  The release timing SHALL then follow REQ-014..016 with k=m.
REQ-018 SW_RST_REQ SHALL be ignored, with no ACK, in ASSERT, HOLD and RELEASE. A request still held when DONE is reached SHALL be serviced per REQ-017.
REQ-019 Each accepted request SHALL produce exactly one ACK. A request still high on the first DONE edge after a completed sequence SHALL count as a new request.
REQ-020 The counter width SHALL be clog2(max(HOLD_CYCLES,STAGE_GAP))+1. The counter SHALL count down and saturate at 0, with no wrap-around.
REQ-021 With NUM_DOMAINS=1, STAGE_GAP SHALL be unused and RST_DONE SHALL rise at edge k+HOLD_CYCLES+1.
REQ-022 Illegal parameter values SHALL stop elaboration with an error message.

Reset
REQ-023 RST=1 sampled at any edge, in any state, SHALL force ASSERT state, DOM_RST all ones, RST_DONE=0, SW_RST_ACK=0, counter=0 and domain index=0.
REQ-024 RST SHALL take priority over a simultaneous SW_RST_REQ; no ACK is issued in that case.
REQ-025 RST asserted mid-sequence SHALL re-assert every already-released domain at that same edge; the sequence restarts from REQ-013 on the next release of RST.

Structure
REQ-026 A shared package rst_seq_pkg SHALL hold the state encodings ST_ASSERT, ST_HOLD, ST_RELEASE, ST_DONE and the counter-width function.
REQ-027 One sub-module, rst_seq_cnt, SHALL implement the loadable saturating down-counter with a zero flag. The FSM and domain index SHALL live in rst_seq_ctrl.

Verification (NUM_DOMAINS=4, HOLD_CYCLES=16, STAGE_GAP=8 unless noted)
REQ-028 Power-on: RST=1 for 5 cycles, then 0 at edge k -> DOM_RST 4'hF until k+16; then 4'hE at k+16, 4'hC at k+24, 4'h8 at k+32, 4'h0 at k+40; RST_DONE=1 at k+41.
REQ-029 Software reset from DONE: SW_RST_REQ=1 at edge m -> DOM_RST=4'hF and RST_DONE=0 at m; SW_RST_ACK high for exactly one cycle; releases at m+16/24/32/40.
REQ-030 Early request: SW_RST_REQ=1 from k+20, held -> no ACK before k+41; ACK at k+41 and sequence restarts; exactly one ACK total once REQ drops after the ACK.
REQ-031 Mid-sequence reset: RST=1 at k+28 (DOM_RST=4'hC) -> DOM_RST=4'hF and RST_DONE=0 at k+28; RST low at edge j -> releases at j+16/24/32/40.
REQ-032 Collision: RST=1 and SW_RST_REQ=1 at the same edge in DONE -> state ASSERT, SW_RST_ACK stays 0.
REQ-033 Degenerate parameters NUM_DOMAINS=1, HOLD_CYCLES=1 -> DOM_RST=0 at k+1, RST_DONE=1 at k+2.
